// File: rtl/instr_stream_encoder_pkg.sv
// instr_stream_encoder_pkg: ALU op codes, MIPS opcode/funct constants and encoder state encoding
package instr_stream_encoder_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_ADDU = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_SUBU = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_NOP  = 4'd15
    } aluop_t;
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_TERM, S_DONE} state_t;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] F_ADD    = 6'b100000;
    localparam logic [5:0] F_ADDU   = 6'b100001;
    localparam logic [5:0] F_SUB    = 6'b100010;
    localparam logic [5:0] F_SUBU   = 6'b100011;
    localparam logic [5:0] F_AND    = 6'b100100;
    localparam logic [5:0] F_OR     = 6'b100101;
    localparam logic [5:0] F_XOR    = 6'b100110;
    localparam logic [5:0] F_SLL    = 6'b000000;
    localparam logic [5:0] F_SRL    = 6'b000010;
    localparam logic [5:0] F_SRA    = 6'b000011;
    typedef struct packed {
        logic        ok;
        logic [31:0] word;
    } enc_t;
endpackage

// File: rtl/instr_stream_encoder_fifo.sv
// sync_fifo: power-of-two circular buffer with occupancy count, async active-low reset
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    assign dout  = mem[rp];
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    always_ff @(posedge clk)
        if (push) mem[wp] <= din;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
endmodule

// File: rtl/instr_stream_encoder.sv
// instr_stream_encoder: encodes ALU requests into MIPS words and streams them into imem
module instr_stream_encoder
    import instr_stream_encoder_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 4,
    parameter bit TERM_EN = 1'b1
) (
    input  logic              CLK,
    input  logic              Reset_L,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              finish,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_aluop,
    input  logic              req_imm_sel,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_shamt,
    input  logic [15:0]       req_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              done,
    output logic              err_sticky,
    output logic [7:0]        err_cnt,
    output logic              addr_wrap
);
    function automatic enc_t encode(input logic [3:0] op, input logic isel, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                                    input logic [15:0] imm);
        enc_t       e;
        logic [5:0] code;
        logic       shift;
        e.ok  = 1'b1;
        code  = '0;
        shift = 1'b0;
        if (isel) begin
            case (op)
                ALU_ADD:  code = OP_ADDI;
                ALU_ADDU: code = OP_ADDIU;
                ALU_AND:  code = OP_ANDI;
                ALU_OR:   code = OP_ORI;
                ALU_XOR:  code = OP_XORI;
                default:  e.ok = 1'b0;
            endcase
            e.word = {code, rs, rt, imm};
        end else begin
            case (op)
                ALU_ADD:  code = F_ADD;
                ALU_ADDU: code = F_ADDU;
                ALU_SUB:  code = F_SUB;
                ALU_SUBU: code = F_SUBU;
                ALU_AND:  code = F_AND;
                ALU_OR:   code = F_OR;
                ALU_XOR:  code = F_XOR;
                ALU_SLL:  begin code = F_SLL; shift = 1'b1; end
                ALU_SRL:  begin code = F_SRL; shift = 1'b1; end
                ALU_SRA:  begin code = F_SRA; shift = 1'b1; end
                default:  e.ok = 1'b0;
            endcase
            e.word = {OP_RTYPE, shift ? 5'd0 : rs, rt, rd, shift ? sh : 5'd0, code};
        end
        return e;
    endfunction

    state_t                   state, state_n;
    enc_t                     enc;
    logic                     accept, push, pop, wr, full, empty;
    logic [31:0]              head;
    logic [$clog2(DEPTH):0]   count;
    logic [ADDR_W:0]          addr_sum;

    assign enc       = encode(req_aluop, req_imm_sel, req_rs, req_rt, req_rd, req_shamt, req_imm);
    assign req_ready = state == S_RUN && !full;
    assign accept    = req_valid && req_ready;
    assign push      = accept && enc.ok;
    assign imem_we   = ((state == S_RUN || state == S_DRAIN) && !empty) || state == S_TERM;
    assign imem_wdata = (imem_we && state != S_TERM) ? head : 32'd0;
    assign wr        = imem_we && imem_ready;
    assign pop       = wr && state != S_TERM;
    assign addr_sum  = {1'b0, imem_addr} + (ADDR_W+1)'(4);
    assign done      = state == S_DONE;

    sync_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
        .clk   (CLK),
        .rst_n (Reset_L),
        .push  (push),
        .pop   (pop),
        .din   (enc.word),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  state_n = start ? S_RUN : S_IDLE;
            S_RUN:   state_n = finish ? S_DRAIN : S_RUN;
            S_DRAIN: state_n = count != '0 ? S_DRAIN : (TERM_EN ? S_TERM : S_DONE);
            S_TERM:  state_n = imem_ready ? S_DONE : S_TERM;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_L)
        if (!Reset_L) begin
            state      <= S_IDLE;
            imem_addr  <= '0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
            addr_wrap  <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && start) begin
                imem_addr  <= base_addr;
                err_sticky <= 1'b0;
                err_cnt    <= '0;
                addr_wrap  <= 1'b0;
            end else begin
                if (wr) begin
                    imem_addr <= addr_sum[ADDR_W-1:0];
                    if (addr_sum[ADDR_W]) addr_wrap <= 1'b1;
                end
                if (accept && !enc.ok) begin
                    err_sticky <= 1'b1;
                    err_cnt    <= err_cnt + {7'd0, err_cnt != 8'hFF};
                end
            end
        end
endmodule

// File: tb/tb_instr_stream_encoder.sv
// tb_instr_stream_encoder: scoreboard bench for the instruction stream encoder
module tb_instr_stream_encoder;
    import instr_stream_encoder_pkg::*;
    logic        CLK, Reset_L, start, finish, req_valid, req_ready, req_imm_sel;
    logic [31:0] base_addr, imem_addr, imem_wdata;
    logic [3:0]  req_aluop;
    logic [4:0]  req_rs, req_rt, req_rd, req_shamt;
    logic [15:0] req_imm;
    logic        imem_we, imem_ready, done, err_sticky, addr_wrap;
    logic [7:0]  err_cnt;
    logic [63:0] q[$];
    logic [31:0] exp_addr;
    logic        accepted;
    int          n_checks, n_fail, wr_seen;

    instr_stream_encoder dut (
        .CLK(CLK), .Reset_L(Reset_L), .start(start), .base_addr(base_addr), .finish(finish),
        .req_valid(req_valid), .req_ready(req_ready), .req_aluop(req_aluop),
        .req_imm_sel(req_imm_sel), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_shamt(req_shamt), .req_imm(req_imm), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_ready(imem_ready), .done(done), .err_sticky(err_sticky),
        .err_cnt(err_cnt), .addr_wrap(addr_wrap)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // reference encoding from the MIPS opcode/funct tables
    function automatic logic [32:0] model(input logic [3:0] op, input logic isel, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh, input logic [15:0] imm);
        logic [5:0] c;
        if (isel) begin
            case (op)
                ALU_ADD:  c = 6'h08;
                ALU_ADDU: c = 6'h09;
                ALU_AND:  c = 6'h0C;
                ALU_OR:   c = 6'h0D;
                ALU_XOR:  c = 6'h0E;
                default:  return 33'd0;
            endcase
            return {1'b1, c, rs, rt, imm};
        end
        case (op)
            ALU_ADD:  c = 6'h20;
            ALU_ADDU: c = 6'h21;
            ALU_SUB:  c = 6'h22;
            ALU_SUBU: c = 6'h23;
            ALU_AND:  c = 6'h24;
            ALU_OR:   c = 6'h25;
            ALU_XOR:  c = 6'h26;
            ALU_SLL:  c = 6'h00;
            ALU_SRL:  c = 6'h02;
            ALU_SRA:  c = 6'h03;
            default:  return 33'd0;
        endcase
        if (op == ALU_SLL || op == ALU_SRL || op == ALU_SRA) return {1'b1, 6'd0, 5'd0, rt, rd, sh, c};
        return {1'b1, 6'd0, rs, rt, rd, 5'd0, c};
    endfunction

    // one clock: observe just after the falling edge what the next rising edge will do
    task automatic cyc();
        logic [32:0] r;
        logic [63:0] e;
        #1;
        if (imem_we && imem_ready) begin
            wr_seen++;
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: addr %h data %h, no write expected", imem_addr, imem_wdata);
            end else begin
                e = q.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL write: got addr %h data %h, expected addr %h data %h",
                             imem_addr, imem_wdata, e[63:32], e[31:0]);
                end
            end
        end
        accepted = req_valid && req_ready;
        if (accepted) begin
            r = model(req_aluop, req_imm_sel, req_rs, req_rt, req_rd, req_shamt, req_imm);
            if (r[32]) begin
                q.push_back({exp_addr, r[31:0]});
                exp_addr += 32'd4;
            end
        end
        @(negedge CLK);
    endtask

    task automatic send(input logic [3:0] op, input logic isel, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm);
        req_aluop = op; req_imm_sel = isel; req_rs = rs; req_rt = rt; req_rd = rd;
        req_shamt = sh; req_imm = imm; req_valid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 50 && !accepted; i++) cyc();
        req_valid = 1'b0;
        n_checks++;
        if (!accepted) begin
            n_fail++;
            $display("FAIL send_timeout: accepted %b, expected 1", accepted);
        end
    endtask

    task automatic flush();
        for (int i = 0; i < 40 && q.size() > 0; i++) cyc();
        repeat (2) cyc();
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL flush: %0d writes outstanding, expected 0", q.size());
        end
    endtask

    task automatic do_start(input logic [31:0] b);
        start = 1'b1; base_addr = b;
        cyc();
        start = 1'b0;
        exp_addr = b;
    endtask

    task automatic test_reset();
        Reset_L = 1'b0;
        repeat (2) @(negedge CLK);
        #1;
        n_checks++;
        if ({req_ready, imem_we, imem_addr, imem_wdata, done, err_sticky, err_cnt, addr_wrap} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b %b %h %h %b %b %h %b, expected all 0", req_ready, imem_we,
                     imem_addr, imem_wdata, done, err_sticky, err_cnt, addr_wrap);
        end
        @(negedge CLK);
        Reset_L = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_basic();
        imem_ready = 1'b1;
        do_start(32'h100);
        send(ALU_ADD, 1'b0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        #1;
        n_checks++;
        if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 32'h100, 32'h00221820}) begin
            n_fail++;
            $display("FAIL add_word: got we %b addr %h data %h, expected 1 00000100 00221820",
                     imem_we, imem_addr, imem_wdata);
        end
        send(ALU_ADD, 1'b1, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF);
        #1;
        n_checks++;
        if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 32'h104, 32'h2022FFFF}) begin
            n_fail++;
            $display("FAIL addi_word: got we %b addr %h data %h, expected 1 00000104 2022ffff",
                     imem_we, imem_addr, imem_wdata);
        end
        send(ALU_SLL, 1'b0, 5'd7, 5'd5, 5'd4, 5'd3, 16'h0);
        #1;
        n_checks++;
        if (imem_wdata !== 32'h000520C0) begin
            n_fail++;
            $display("FAIL sll_word: got %h, expected 000520c0", imem_wdata);
        end
        flush();
    endtask

    task automatic test_backpressure();
        int  w0;
        logic any;
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(ALU_ADD, 1'b0, 5'(i), 5'(i + 1), 5'(i + 2), 5'd0, 16'h0);
        #1;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_ready: got %b, expected 0", req_ready);
        end
        req_aluop = ALU_XOR; req_imm_sel = 1'b0; req_rs = 5'd9; req_rt = 5'd10; req_rd = 5'd11;
        req_valid = 1'b1;
        any = 1'b0;
        repeat (3) begin
            cyc();
            any |= accepted;
        end
        n_checks++;
        if (any !== 1'b0) begin
            n_fail++;
            $display("FAIL fifth_held: accepted %b, expected 0", any);
        end
        imem_ready = 1'b1;
        w0 = wr_seen;
        repeat (5) begin
            cyc();
            if (accepted) req_valid = 1'b0;
        end
        n_checks++;
        if (wr_seen - w0 != 5 || q.size() != 0) begin
            n_fail++;
            $display("FAIL burst: %0d writes with %0d left, expected 5 with 0 left", wr_seen - w0, q.size());
        end
    endtask

    task automatic test_illegal();
        imem_ready = 1'b1;
        send(ALU_SUB, 1'b1, 5'd1, 5'd2, 5'd0, 5'd0, 16'h1234);
        #1;
        n_checks++;
        if ({imem_we, err_sticky, err_cnt} !== {1'b0, 1'b1, 8'd1}) begin
            n_fail++;
            $display("FAIL illegal_sub: got we %b sticky %b cnt %0d, expected 0 1 1", imem_we, err_sticky, err_cnt);
        end
        send(ALU_NOP, 1'b0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        n_checks++;
        if (err_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL illegal_nop: got cnt %0d, expected 2", err_cnt);
        end
        send(ALU_ADDU, 1'b0, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0);
        flush();
        for (int i = 0; i < 256; i++) send(ALU_NOP, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        n_checks++;
        if (err_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL err_saturate: got cnt %0d, expected 255", err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        imem_ready = 1'b1;
        for (int i = 0; i < 10; i++)
            send(4'(i), 1'b0, 5'(i + 1), 5'(i + 2), 5'(i + 3), 5'(i + 17), 16'h0);
        send(ALU_ADD, 1'b1, 5'd3, 5'd4, 5'd0, 5'd0, 16'($urandom));
        send(ALU_ADDU, 1'b1, 5'd5, 5'd6, 5'd0, 5'd0, 16'($urandom));
        send(ALU_AND, 1'b1, 5'd7, 5'd8, 5'd0, 5'd0, 16'($urandom));
        send(ALU_OR, 1'b1, 5'd9, 5'd10, 5'd0, 5'd0, 16'($urandom));
        send(ALU_XOR, 1'b1, 5'd31, 5'd30, 5'd0, 5'd0, 16'($urandom));
        flush();
    endtask

    task automatic test_finish();
        int ndone;
        imem_ready = 1'b0;
        send(ALU_OR, 1'b0, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0);
        send(ALU_SRA, 1'b0, 5'd2, 5'd2, 5'd2, 5'd2, 16'h0);
        send(ALU_ANDI_SUB(), 1'b0, 5'd3, 5'd3, 5'd3, 5'd0, 16'h0);
        finish = 1'b1;
        cyc();
        finish = 1'b0;
        q.push_back({exp_addr, 32'h0});
        #1;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_ready: got %b, expected 0", req_ready);
        end
        imem_ready = 1'b1;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (done) ndone++;
        end
        n_checks++;
        if (ndone != 1 || q.size() != 0) begin
            n_fail++;
            $display("FAIL done_pulse: done for %0d cycles with %0d writes left, expected 1 and 0", ndone, q.size());
        end
        n_checks++;
        if ({req_ready, imem_we, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_after_done: got %b, expected 000", {req_ready, imem_we, done});
        end
    endtask

    function automatic logic [3:0] ALU_ANDI_SUB();
        return ALU_SUBU;
    endfunction

    task automatic test_wrap();
        do_start(32'hFFFF_FFFC);
        #1;
        n_checks++;
        if ({err_sticky, err_cnt, addr_wrap, imem_addr} !== {1'b0, 8'd0, 1'b0, 32'hFFFF_FFFC}) begin
            n_fail++;
            $display("FAIL start_clear: got %b %0d %b %h, expected 0 0 0 fffffffc",
                     err_sticky, err_cnt, addr_wrap, imem_addr);
        end
        imem_ready = 1'b1;
        send(ALU_ADD, 1'b0, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0);
        send(ALU_XOR, 1'b1, 5'd2, 5'd2, 5'd0, 5'd0, 16'hA5A5);
        flush();
        n_checks++;
        if (addr_wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL addr_wrap: got %b, expected 1", addr_wrap);
        end
    endtask

    task automatic test_reset_drain();
        int w0;
        imem_ready = 1'b0;
        send(ALU_ADD, 1'b0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        send(ALU_SUB, 1'b0, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0);
        finish = 1'b1;
        cyc();
        finish = 1'b0;
        cyc();
        #2 Reset_L = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, imem_we, imem_addr, imem_wdata, done, err_sticky, err_cnt, addr_wrap} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_drain: got %b %b %h %h %b %b %h %b, expected all 0", req_ready, imem_we,
                     imem_addr, imem_wdata, done, err_sticky, err_cnt, addr_wrap);
        end
        q.delete();
        @(negedge CLK);
        Reset_L = 1'b1;
        @(negedge CLK);
        do_start(32'h200);
        #1;
        n_checks++;
        if (imem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL fifo_emptied: got we %b, expected 0", imem_we);
        end
        imem_ready = 1'b1;
        w0 = wr_seen;
        send(ALU_OR, 1'b1, 5'd8, 5'd9, 5'd0, 5'd0, 16'h00FF);
        flush();
        n_checks++;
        if (wr_seen - w0 != 1) begin
            n_fail++;
            $display("FAIL post_reset_writes: got %0d, expected 1", wr_seen - w0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_fail = 0; wr_seen = 0; exp_addr = '0; accepted = 1'b0;
        start = 1'b0; finish = 1'b0; base_addr = '0; req_valid = 1'b0; req_aluop = '0;
        req_imm_sel = 1'b0; req_rs = '0; req_rt = '0; req_rd = '0; req_shamt = '0; req_imm = '0;
        imem_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_illegal();
        test_back_to_back();
        test_finish();
        test_wrap();
        test_reset_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
